// File: rtl/apb_arbiter_2m_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_arbiter_2m_pkg
// Description : Shared definitions for the two-master APB arbiter: FSM state
//               encoding, arbitration mode constants, grant identifiers and
//               timeout counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_arbiter_2m_pkg;

  // Downstream bridge FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_t;

  // Values of the ARB_MODE parameter.
  localparam int c_ARB_FIXED = 0;
  localparam int c_ARB_RR    = 1;

  // Encoding of the single grant/last-grant register.
  localparam logic c_GNT_S0 = 1'b0;
  localparam logic c_GNT_S1 = 1'b1;

  // Width of the downstream ACCESS timeout counter.
  localparam int c_TO_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/apb_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_rr2
// Description : Two-requester grant logic, fixed priority or round-robin.
//               Purely combinational; the caller registers the result.
// Ports       : i_req0/i_req1 - requests from S0/S1
//               i_mode        - 0 = fixed priority (S0 wins), 1 = round-robin
//               i_last        - last granted master (0 = S0, 1 = S1)
//               o_gnt         - one-hot grant, bit n = Sn
// Revision    : 1.0 - initial release
// ============================================================================
module apb_arb_rr2
  import apb_arbiter_2m_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_mode,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req0 && i_req1) begin
      // Contention: fixed mode always favours S0; round-robin favours
      // whichever master did not win last time.
      if (!i_mode || (i_last == c_GNT_S1)) begin
        o_gnt = 2'b01;
      end else begin
        o_gnt = 2'b10;
      end
    end else if (i_req0) begin
      o_gnt = 2'b01;
    end else if (i_req1) begin
      o_gnt = 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module      : apb_arbiter_2m
// Description : Arbitrates two upstream APB4 masters (S0, S1) onto a single
//               downstream APB4 port. Each transfer re-arbitrates in IDLE,
//               runs one SETUP cycle and waits in ACCESS for M_PREADY or an
//               optional timeout that returns an error to the granted master.
// Parameters  : ARB_MODE - 0 = fixed priority (S0 wins), 1 = round-robin
//               TIMEOUT  - max downstream ACCESS cycles, 0 disables
// Ports       : PCLK, PRESETn (async, active-low)
//               S0_*/S1_*  - upstream APB4 slave ports
//               M_*        - downstream APB4 master port
// Revision    : 1.0 - initial release
// ============================================================================
module apb_arbiter_2m
  import apb_arbiter_2m_pkg::*;
#(
  parameter int ARB_MODE = 1,
  parameter int TIMEOUT  = 0
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  // upstream master 0
  input  logic        S0_PSEL,
  input  logic [31:0] S0_PADDR,
  input  logic        S0_PENABLE,
  input  logic        S0_PWRITE,
  input  logic [31:0] S0_PWDATA,
  input  logic [3:0]  S0_PSTRB,
  input  logic [2:0]  S0_PPROT,
  output logic [31:0] S0_PRDATA,
  output logic        S0_PREADY,
  output logic        S0_PSLVERR,
  // upstream master 1
  input  logic        S1_PSEL,
  input  logic [31:0] S1_PADDR,
  input  logic        S1_PENABLE,
  input  logic        S1_PWRITE,
  input  logic [31:0] S1_PWDATA,
  input  logic [3:0]  S1_PSTRB,
  input  logic [2:0]  S1_PPROT,
  output logic [31:0] S1_PRDATA,
  output logic        S1_PREADY,
  output logic        S1_PSLVERR,
  // downstream slave
  output logic        M_PSEL,
  output logic        M_PENABLE,
  output logic        M_PWRITE,
  output logic [31:0] M_PADDR,
  output logic [31:0] M_PWDATA,
  output logic [3:0]  M_PSTRB,
  output logic [2:0]  M_PPROT,
  input  logic [31:0] M_PRDATA,
  input  logic        M_PREADY,
  input  logic        M_PSLVERR
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  // Current grant; also serves as last-grant for round-robin, since it is
  // only rewritten when a new grant is taken.
  logic       r_gnt;
  logic [1:0] w_gnt;
  logic       w_mode;
  logic       w_active;
  logic       w_deliver;
  logic       w_to_fire;
  logic       w_rsp_ready;
  logic       w_rsp_err;
  logic [31:0] w_rsp_rdata;

  // Upstream PENABLE carries no information the bridge needs: grant is taken
  // on PSEL alone and the response is returned whenever ACCESS ends.
  logic w_unused_penable;
  assign w_unused_penable = S0_PENABLE ^ S1_PENABLE;

  assign w_mode = (ARB_MODE == c_ARB_RR) ? 1'b1 : 1'b0;

  apb_arb_rr2 u_arb (
    .i_req0 (S0_PSEL),
    .i_req1 (S1_PSEL),
    .i_mode (w_mode),
    .i_last (r_gnt),
    .o_gnt  (w_gnt)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
      r_gnt   <= c_GNT_S1;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && (|w_gnt)) begin
        r_gnt <= w_gnt[1];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (|w_gnt) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (M_PREADY || w_to_fire) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Timeout
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam logic [c_TO_CNT_W-1:0] c_TO_LAST = c_TO_CNT_W'(TIMEOUT - 1);
      localparam logic [c_TO_CNT_W-1:0] c_TO_INC  = c_TO_CNT_W'(1);
      logic [c_TO_CNT_W-1:0] r_to_cnt;

      // Cleared while in SETUP so it reads zero on the first ACCESS cycle.
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          r_to_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
          r_to_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !M_PREADY) begin
          r_to_cnt <= r_to_cnt + c_TO_INC;
        end
      end

      // Fires on the TIMEOUT-th waiting ACCESS cycle (count TIMEOUT-1 before
      // this cycle's increment). A real M_PREADY in that cycle wins.
      assign w_to_fire = (r_state == ST_ACCESS) && !M_PREADY &&
                         (r_to_cnt == c_TO_LAST);
    end else begin : g_no_timeout
      assign w_to_fire = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Downstream control and payload
  // --------------------------------------------------------------------------
  assign w_active  = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign M_PSEL    = w_active;
  assign M_PENABLE = (r_state == ST_ACCESS);

  always_comb begin
    M_PADDR  = '0;
    M_PWRITE = 1'b0;
    M_PWDATA = '0;
    M_PSTRB  = '0;
    M_PPROT  = '0;
    if (w_active) begin
      if (r_gnt == c_GNT_S1) begin
        M_PADDR  = S1_PADDR;
        M_PWRITE = S1_PWRITE;
        M_PWDATA = S1_PWDATA;
        M_PSTRB  = S1_PSTRB;
        M_PPROT  = S1_PPROT;
      end else begin
        M_PADDR  = S0_PADDR;
        M_PWRITE = S0_PWRITE;
        M_PWDATA = S0_PWDATA;
        M_PSTRB  = S0_PSTRB;
        M_PPROT  = S0_PPROT;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Upstream response
  // --------------------------------------------------------------------------
  assign w_rsp_ready = M_PREADY | w_to_fire;
  assign w_rsp_err   = M_PSLVERR | w_to_fire;
  assign w_rsp_rdata = w_to_fire ? 32'hFFFF_FFFF : M_PRDATA;

  // A master that dropped PSEL mid-transfer gets nothing back; the downstream
  // transfer still runs to completion so the slave sees legal APB.
  assign w_deliver = (r_state == ST_ACCESS) &&
                     ((r_gnt == c_GNT_S1) ? S1_PSEL : S0_PSEL);

  always_comb begin
    S0_PREADY  = 1'b0;
    S0_PSLVERR = 1'b0;
    S0_PRDATA  = '0;
    S1_PREADY  = 1'b0;
    S1_PSLVERR = 1'b0;
    S1_PRDATA  = '0;
    if (w_deliver) begin
      if (r_gnt == c_GNT_S1) begin
        S1_PREADY  = w_rsp_ready;
        S1_PSLVERR = w_rsp_err;
        S1_PRDATA  = w_rsp_rdata;
      end else begin
        S0_PREADY  = w_rsp_ready;
        S0_PSLVERR = w_rsp_err;
        S0_PRDATA  = w_rsp_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_arbiter_2m
// Description : Directed bench for apb_arbiter_2m. Instance 0 runs fixed
//               priority without timeout, instance 1 runs round-robin with
//               TIMEOUT=8. Each instance has its own masters and slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_arbiter_2m;

  localparam int NI = 2;

  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  logic        s_psel    [NI][2];
  logic [31:0] s_paddr   [NI][2];
  logic        s_penable [NI][2];
  logic        s_pwrite  [NI][2];
  logic [31:0] s_pwdata  [NI][2];
  logic [3:0]  s_pstrb   [NI][2];
  logic [2:0]  s_pprot   [NI][2];
  logic [31:0] s_prdata  [NI][2];
  logic        s_pready  [NI][2];
  logic        s_pslverr [NI][2];

  logic        m_psel    [NI];
  logic        m_penable [NI];
  logic        m_pwrite  [NI];
  logic [31:0] m_paddr   [NI];
  logic [31:0] m_pwdata  [NI];
  logic [3:0]  m_pstrb   [NI];
  logic [2:0]  m_pprot   [NI];
  logic [31:0] m_prdata  [NI];
  logic        m_pready  [NI];
  logic        m_pslverr [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      apb_arbiter_2m #(.ARB_MODE(gi), .TIMEOUT((gi == 1) ? 8 : 0)) u_dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .S0_PSEL    (s_psel[gi][0]),
        .S0_PADDR   (s_paddr[gi][0]),
        .S0_PENABLE (s_penable[gi][0]),
        .S0_PWRITE  (s_pwrite[gi][0]),
        .S0_PWDATA  (s_pwdata[gi][0]),
        .S0_PSTRB   (s_pstrb[gi][0]),
        .S0_PPROT   (s_pprot[gi][0]),
        .S0_PRDATA  (s_prdata[gi][0]),
        .S0_PREADY  (s_pready[gi][0]),
        .S0_PSLVERR (s_pslverr[gi][0]),
        .S1_PSEL    (s_psel[gi][1]),
        .S1_PADDR   (s_paddr[gi][1]),
        .S1_PENABLE (s_penable[gi][1]),
        .S1_PWRITE  (s_pwrite[gi][1]),
        .S1_PWDATA  (s_pwdata[gi][1]),
        .S1_PSTRB   (s_pstrb[gi][1]),
        .S1_PPROT   (s_pprot[gi][1]),
        .S1_PRDATA  (s_prdata[gi][1]),
        .S1_PREADY  (s_pready[gi][1]),
        .S1_PSLVERR (s_pslverr[gi][1]),
        .M_PSEL     (m_psel[gi]),
        .M_PENABLE  (m_penable[gi]),
        .M_PWRITE   (m_pwrite[gi]),
        .M_PADDR    (m_paddr[gi]),
        .M_PWDATA   (m_pwdata[gi]),
        .M_PSTRB    (m_pstrb[gi]),
        .M_PPROT    (m_pprot[gi]),
        .M_PRDATA   (m_prdata[gi]),
        .M_PREADY   (m_pready[gi]),
        .M_PSLVERR  (m_pslverr[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge PCLK);
  endtask

  task automatic mreq(input int k, input int m, input logic [31:0] a,
                      input logic w, input logic [31:0] d);
    s_psel[k][m]    = 1'b1;
    s_penable[k][m] = 1'b0;
    s_paddr[k][m]   = a;
    s_pwrite[k][m]  = w;
    s_pwdata[k][m]  = d;
    s_pstrb[k][m]   = w ? 4'hF : 4'h0;
    s_pprot[k][m]   = (m == 0) ? 3'b010 : 3'b001;
  endtask

  task automatic midle(input int k, input int m);
    s_psel[k][m]    = 1'b0;
    s_penable[k][m] = 1'b0;
    s_paddr[k][m]   = '0;
    s_pwrite[k][m]  = 1'b0;
    s_pwdata[k][m]  = '0;
    s_pstrb[k][m]   = '0;
    s_pprot[k][m]   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          rem   [NI][2];
  logic        done  [NI][2];
  logic [4:0]  order [NI];
  int          ngr   [NI];

  initial begin
    PRESETn = 1'b0;
    for (int k = 0; k < NI; k++) begin
      midle(k, 0);
      midle(k, 1);
      m_pready[k]  = 1'b1;
      m_pslverr[k] = 1'b0;
      m_prdata[k]  = '0;
    end
    #3;
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("rst.k%0d.mpsel", k), m_psel[k], 1'b0);
      chk1($sformatf("rst.k%0d.mpen", k), m_penable[k], 1'b0);
      chk1($sformatf("rst.k%0d.s0rdy", k), s_pready[k][0], 1'b0);
    end
    step();
    PRESETn = 1'b1;
    step();

    // ---- single write from S0, slave ready immediately ----
    for (int k = 0; k < NI; k++) begin
      mreq(k, 0, 32'h10, 1'b1, 32'hA5A5_0001);
      m_prdata[k] = 32'hDEAD_BEEF;
    end
    mid();
    for (int k = 0; k < NI; k++) chk1($sformatf("A.k%0d.idle.mpsel", k), m_psel[k], 1'b0);
    step();
    for (int k = 0; k < NI; k++) s_penable[k][0] = 1'b1;
    mid();
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("A.k%0d.setup.mpsel", k), m_psel[k], 1'b1);
      chk1($sformatf("A.k%0d.setup.mpen", k), m_penable[k], 1'b0);
      chk32($sformatf("A.k%0d.paddr", k), m_paddr[k], 32'h10);
      chk32($sformatf("A.k%0d.pwdata", k), m_pwdata[k], 32'hA5A5_0001);
      chk1($sformatf("A.k%0d.pwrite", k), m_pwrite[k], 1'b1);
      chk32($sformatf("A.k%0d.pstrb", k), 32'(m_pstrb[k]), 32'hF);
      chk32($sformatf("A.k%0d.pprot", k), 32'(m_pprot[k]), 32'h2);
      chk1($sformatf("A.k%0d.setup.s0rdy", k), s_pready[k][0], 1'b0);
    end
    step();
    mid();
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("A.k%0d.acc.mpen", k), m_penable[k], 1'b1);
      chk1($sformatf("A.k%0d.acc.s0rdy", k), s_pready[k][0], 1'b1);
      chk1($sformatf("A.k%0d.acc.s0err", k), s_pslverr[k][0], 1'b0);
      chk1($sformatf("A.k%0d.acc.s1rdy", k), s_pready[k][1], 1'b0);
      chk32($sformatf("A.k%0d.acc.s1rdata", k), s_prdata[k][1], 32'h0);
    end
    step();
    for (int k = 0; k < NI; k++) midle(k, 0);
    mid();
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("A.k%0d.done.mpsel", k), m_psel[k], 1'b0);
      chk32($sformatf("A.k%0d.done.paddr", k), m_paddr[k], 32'h0);
    end

    // ---- reset, then simultaneous reads ----
    step();
    PRESETn = 1'b0;
    step();
    PRESETn = 1'b1;
    step();
    for (int k = 0; k < NI; k++) begin
      mreq(k, 0, 32'h20, 1'b0, 32'h0);
      mreq(k, 1, 32'h30, 1'b0, 32'h0);
    end
    mid();
    step();
    for (int k = 0; k < NI; k++) begin
      s_penable[k][0] = 1'b1;
      s_penable[k][1] = 1'b1;
    end
    mid();
    for (int k = 0; k < NI; k++) begin
      chk32($sformatf("B.k%0d.first.paddr", k), m_paddr[k], 32'h20);
      chk1($sformatf("B.k%0d.first.s1rdy", k), s_pready[k][1], 1'b0);
    end
    step();
    for (int k = 0; k < NI; k++) m_prdata[k] = 32'h1111_0000;
    mid();
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("B.k%0d.s0rdy", k), s_pready[k][0], 1'b1);
      chk32($sformatf("B.k%0d.s0rdata", k), s_prdata[k][0], 32'h1111_0000);
      chk1($sformatf("B.k%0d.s1wait", k), s_pready[k][1], 1'b0);
      chk32($sformatf("B.k%0d.s1rdata0", k), s_prdata[k][1], 32'h0);
    end
    step();
    for (int k = 0; k < NI; k++) midle(k, 0);
    mid();
    for (int k = 0; k < NI; k++) chk1($sformatf("B.k%0d.idle.s1rdy", k), s_pready[k][1], 1'b0);
    step();
    mid();
    for (int k = 0; k < NI; k++) begin
      chk32($sformatf("B.k%0d.second.paddr", k), m_paddr[k], 32'h30);
      chk1($sformatf("B.k%0d.second.mpen", k), m_penable[k], 1'b0);
    end
    step();
    for (int k = 0; k < NI; k++) m_prdata[k] = 32'h2222_0000;
    mid();
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("B.k%0d.s1rdy", k), s_pready[k][1], 1'b1);
      chk32($sformatf("B.k%0d.s1rdata", k), s_prdata[k][1], 32'h2222_0000);
      chk32($sformatf("B.k%0d.s0rdata0", k), s_prdata[k][0], 32'h0);
    end
    step();
    for (int k = 0; k < NI; k++) midle(k, 1);

    // ---- S0 four back-to-back reads, S1 one pending write ----
    for (int k = 0; k < NI; k++) begin
      ngr[k] = 0;
      order[k] = '0;
      m_pready[k] = 1'b1;
      mreq(k, 0, 32'h100, 1'b0, 32'h0);
      mreq(k, 1, 32'h200, 1'b1, 32'h5555_AAAA);
      rem[k][0] = 3;
      rem[k][1] = 0;
    end
    for (int cyc = 0; cyc < 24; cyc++) begin
      mid();
      for (int k = 0; k < NI; k++) begin
        if (m_psel[k] && !m_penable[k]) begin
          if (ngr[k] < 5) order[k][ngr[k]] = m_paddr[k][9];
          ngr[k]++;
        end
        for (int m = 0; m < 2; m++) done[k][m] = s_pready[k][m];
      end
      step();
      for (int k = 0; k < NI; k++) begin
        for (int m = 0; m < 2; m++) begin
          if (done[k][m]) begin
            if (rem[k][m] > 0) begin
              mreq(k, m, 32'h100 + 32'(4 * (4 - rem[k][m])), 1'b0, 32'h0);
              rem[k][m]--;
            end else begin
              midle(k, m);
            end
          end else if (s_psel[k][m]) begin
            s_penable[k][m] = 1'b1;
          end
        end
      end
    end
    chk32("C.fixed.ngrants", ngr[0], 5);
    chk32("C.fixed.order", 32'(order[0]), 32'h10);
    chk32("C.rr.ngrants", ngr[1], 5);
    chk32("C.rr.order", 32'(order[1]), 32'h02);

    // ---- slave stalls: timeout on instance 1, plain wait on instance 0 ----
    step();
    for (int k = 0; k < NI; k++) begin
      mreq(k, 0, 32'h40, 1'b0, 32'h0);
      m_pready[k] = 1'b0;
      m_pslverr[k] = 1'b0;
      m_prdata[k] = 32'h1234_5678;
    end
    mid();
    step();
    for (int k = 0; k < NI; k++) s_penable[k][0] = 1'b1;
    mid();
    for (int a = 1; a <= 7; a++) begin
      step();
      mid();
      chk1($sformatf("D.wait%0d.s0rdy", a), s_pready[1][0], 1'b0);
      chk1($sformatf("D.wait%0d.mpen", a), m_penable[1], 1'b1);
    end
    step();
    mid();
    chk1("D.to.s0rdy", s_pready[1][0], 1'b1);
    chk1("D.to.s0err", s_pslverr[1][0], 1'b1);
    chk32("D.to.s0rdata", s_prdata[1][0], 32'hFFFF_FFFF);
    chk1("D.noto.s0rdy", s_pready[0][0], 1'b0);
    chk32("D.noto.s0rdata", s_prdata[0][0], 32'h1234_5678);
    step();
    midle(1, 0);
    m_pready[0] = 1'b1;
    mid();
    chk1("D.to.next.mpsel", m_psel[1], 1'b0);
    chk1("D.noto.late.s0rdy", s_pready[0][0], 1'b1);
    chk1("D.noto.late.s0err", s_pslverr[0][0], 1'b0);
    step();
    midle(0, 0);
    mid();

    // ---- M_PREADY in the timeout cycle wins (instance 1, master S1) ----
    step();
    mreq(1, 1, 32'h44, 1'b0, 32'h0);
    m_pready[1] = 1'b0;
    mid();
    step();
    s_penable[1][1] = 1'b1;
    mid();
    for (int a = 1; a <= 7; a++) begin
      step();
      mid();
    end
    step();
    m_pready[1] = 1'b1;
    m_prdata[1] = 32'hCAFE_F00D;
    m_pslverr[1] = 1'b0;
    mid();
    chk1("E.race.s1rdy", s_pready[1][1], 1'b1);
    chk1("E.race.s1err", s_pslverr[1][1], 1'b0);
    chk32("E.race.s1rdata", s_prdata[1][1], 32'hCAFE_F00D);
    step();
    midle(1, 1);
    mid();
    chk1("E.race.after.mpsel", m_psel[1], 1'b0);

    // ---- granted master drops PSEL mid-transfer ----
    step();
    mreq(1, 0, 32'h60, 1'b1, 32'h0000_0060);
    mid();
    step();
    midle(1, 0);
    mid();
    chk1("F.drop.setup.mpsel", m_psel[1], 1'b1);
    step();
    mid();
    chk1("F.drop.acc.mpen", m_penable[1], 1'b1);
    chk1("F.drop.acc.s0rdy", s_pready[1][0], 1'b0);
    step();
    mid();
    chk1("F.drop.idle.mpsel", m_psel[1], 1'b0);

    // ---- reset during ACCESS, pending S1 granted after release ----
    step();
    for (int k = 0; k < NI; k++) begin
      mreq(k, 0, 32'h58, 1'b0, 32'h0);
      m_pready[k] = 1'b0;
      m_pslverr[k] = 1'b1;
      m_prdata[k] = 32'h7777_7777;
    end
    mid();
    step();
    for (int k = 0; k < NI; k++) begin
      s_penable[k][0] = 1'b1;
      mreq(k, 1, 32'h50, 1'b1, 32'h0BAD_CAFE);
    end
    mid();
    step();
    for (int k = 0; k < NI; k++) s_penable[k][1] = 1'b1;
    mid();
    for (int k = 0; k < NI; k++) chk1($sformatf("G.k%0d.acc.s0err", k), s_pslverr[k][0], 1'b1);
    step();
    #2;
    PRESETn = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("G.k%0d.rst.mpsel", k), m_psel[k], 1'b0);
      chk1($sformatf("G.k%0d.rst.mpen", k), m_penable[k], 1'b0);
      chk32($sformatf("G.k%0d.rst.paddr", k), m_paddr[k], 32'h0);
      chk1($sformatf("G.k%0d.rst.s0err", k), s_pslverr[k][0], 1'b0);
      chk32($sformatf("G.k%0d.rst.s0rdata", k), s_prdata[k][0], 32'h0);
    end
    step();
    PRESETn = 1'b1;
    for (int k = 0; k < NI; k++) begin
      midle(k, 0);
      m_pslverr[k] = 1'b0;
      m_pready[k] = 1'b1;
    end
    mid();
    for (int k = 0; k < NI; k++) chk1($sformatf("G.k%0d.idle.mpsel", k), m_psel[k], 1'b0);
    step();
    mid();
    for (int k = 0; k < NI; k++) begin
      chk1($sformatf("G.k%0d.setup.mpsel", k), m_psel[k], 1'b1);
      chk32($sformatf("G.k%0d.setup.paddr", k), m_paddr[k], 32'h50);
      chk32($sformatf("G.k%0d.setup.pwdata", k), m_pwdata[k], 32'h0BAD_CAFE);
    end
    step();
    mid();
    for (int k = 0; k < NI; k++) chk1($sformatf("G.k%0d.acc.s1rdy", k), s_pready[k][1], 1'b1);
    step();
    for (int k = 0; k < NI; k++) midle(k, 1);
    mid();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
